// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared instruction/data memory port (core vs. DMA),
// tracking one outstanding read. Define MEM_ARB_LOCK_EN to add the d_lock DMA bus lock.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic          d_lock,
`endif
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       last_dma;
  logic       owner_dma;
  logic       free;
  logic       lock;
  logic       c_win;
  logic       d_win;
  logic       rd_grant;

`ifdef MEM_ARB_LOCK_EN
  assign lock = d_lock & last_dma;
`else
  assign lock = 1'b0;
`endif

  // Free when idle, or in the read-expiry cycle so the next access can overlap the return.
  assign free  = ~rst & ((state == IDLE) | (cnt == 2'd0));
  assign c_win = c_req & ~lock & (~d_req | last_dma);
  assign d_win = d_req & (lock | ~c_req | ~last_dma);
  assign c_gnt = free & c_win;
  assign d_gnt = free & d_win;

  assign m_en     = c_gnt | d_gnt;
  assign m_we     = (c_gnt & c_we) | (d_gnt & d_we);
  assign m_addr   = d_gnt ? d_addr  : c_addr;
  assign m_wdata  = d_gnt ? d_wdata : c_wdata;
  assign rd_grant = m_en & ~m_we;

  assign c_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // rvalid is registered one cycle ahead: set on the edge entering the expiry cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dma  <= 1'b1;
      owner_dma <= 1'b0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (m_en) last_dma <= d_gnt;
      if (rd_grant) begin
        state     <= RD_WAIT;
        cnt       <= LAT_M1;
        owner_dma <= d_gnt;
        if (RD_LAT == 1) begin
          c_rvalid <= c_gnt;
          d_rvalid <= d_gnt;
        end
      end else if (state == RD_WAIT) begin
        if (cnt == 2'd0) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            c_rvalid <= ~owner_dma;
            d_rvalid <= owner_dma;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural memory, per-port request drivers,
// and an independent arbitration model that queues expected read returns.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  typedef struct {logic dma; logic [31:0] data; int unsigned due;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MEM_ARB_LOCK_EN
    .d_lock(d_lock),
`endif
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory macro with LAT-cycle read pipeline.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe [LAT];
  assign m_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[9:2]] <= m_wdata;
    pipe[0] <= mem[m_addr[9:2]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t cq[$], dq[$];
  exp_t sb[$];
  logic [7:0] glog[$];
  bit c_took = 0, d_took = 0;
  int unsigned c_gnt_n = 0, d_gnt_n = 0, c_rv_n = 0;
  int unsigned c_gnt_cyc = 0, d_gnt_cyc = 0, c_rv_cyc = 0;
  logic [31:0] c_rv_data = '0;

  // Port drivers: hold a request until its grant is seen, then present the next one.
  initial forever begin
    @(posedge clk); #1;
    if (c_req && c_took) void'(cq.pop_front());
    c_took = 0;
    if (cq.size() > 0) begin
      c_req = 1'b1; c_we = cq[0].we; c_addr = cq[0].addr; c_wdata = cq[0].wdata;
    end else c_req = 1'b0;
  end

  initial forever begin
    @(posedge clk); #1;
    if (d_req && d_took) void'(dq.pop_front());
    d_took = 0;
    if (dq.size() > 0) begin
      d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
    end else d_req = 1'b0;
  end

  // Reference arbitration model and scoreboard, evaluated mid-cycle.
  bit m_last_d = 1'b1;
  int unsigned free_at = 0;
  always @(negedge clk) begin
    bit erc, erd, ec, ed, lk, ewe;
    erc = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].dma;
    erd = (sb.size() > 0) && (sb[0].due == cyc) && sb[0].dma;
    check("c_rvalid", c_rvalid, erc);
    check("d_rvalid", d_rvalid, erd);
    if (erc) check("c_rdata", c_rdata, sb[0].data);
    if (erd) check("d_rdata", d_rdata, sb[0].data);
    if (erc || erd) void'(sb.pop_front());
    if (c_rvalid) begin c_rv_n++; c_rv_cyc = cyc; c_rv_data = c_rdata; end
    if (c_gnt) begin c_took = 1; c_gnt_n++; c_gnt_cyc = cyc; glog.push_back(8'h43); end
    if (d_gnt) begin d_took = 1; d_gnt_n++; d_gnt_cyc = cyc; glog.push_back(8'h44); end
    if (rst) begin
      check("rst_c_gnt", c_gnt, 1'b0);
      check("rst_d_gnt", d_gnt, 1'b0);
      check("rst_m_en", m_en, 1'b0);
      sb.delete();
      m_last_d = 1'b1;
      free_at = cyc + 1;
    end else begin
      lk = LOCK_EN && d_lock && m_last_d;
      ec = (cyc >= free_at) && c_req && !lk && (!d_req || m_last_d);
      ed = (cyc >= free_at) && d_req && (lk || !c_req || !m_last_d);
      ewe = ec ? c_we : (ed ? d_we : 1'b0);
      check("c_gnt", c_gnt, ec);
      check("d_gnt", d_gnt, ed);
      check("m_en", m_en, ec | ed);
      check("m_we", m_we, ewe);
      check("m_addr", m_addr, ed ? d_addr : c_addr);
      if (ec || ed) begin
        m_last_d = ed;
        if (ewe) begin
          check("m_wdata", m_wdata, ed ? d_wdata : c_wdata);
          ref_mem[ed ? d_addr[9:2] : c_addr[9:2]] = ed ? d_wdata : c_wdata;
        end else begin
          sb.push_back('{dma: ed, data: ref_mem[ed ? d_addr[9:2] : c_addr[9:2]], due: cyc + LAT});
          free_at = cyc + LAT;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (cq.size() == 0 && dq.size() == 0 && sb.size() == 0 && !c_req && !d_req) begin
        done = 1; break;
      end
    end
    if (!done) check("idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_c_gnt(input int unsigned target);
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (c_gnt_n >= target) begin done = 1; break; end
    end
    if (!done) check("c_gnt_timeout", 1, 0);
  endtask

  task automatic wait_d_gnt(input int unsigned target);
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (d_gnt_n >= target) begin done = 1; break; end
    end
    if (!done) check("d_gnt_timeout", 1, 0);
  endtask

  initial begin
    int n0;
    int unsigned nrv, ncg;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    do_reset();

    // Lone core read: zero-latency grant, data LAT cycles later.
    cq.push_back('{we: 1'b0, addr: 32'h100, wdata: '0});
    wait_idle();
    check("t1_latency", c_rv_cyc - c_gnt_cyc, LAT);
    check("t1_rdata", c_rv_data, 32'hA500_0040);

    // Continuous contention: strict alternation starting with core.
    do_reset();
    n0 = glog.size();
    for (int i = 0; i < 4; i++) begin
      cq.push_back('{we: 1'b0, addr: 32'(i * 4), wdata: '0});
      dq.push_back('{we: 1'b0, addr: 32'(32'h200 + i * 4), wdata: '0});
    end
    wait_idle();
    check("t2_grants", glog.size() - n0, 8);
    for (int i = 0; i < 8; i++)
      if (n0 + i < glog.size()) check("t2_order", glog[n0+i], (i % 2) ? 8'h44 : 8'h43);

    // DMA write then core readback.
    dq.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hDEADBEEF});
    wait_idle();
    cq.push_back('{we: 1'b0, addr: 32'h40, wdata: '0});
    wait_idle();
    check("t3_rdata", c_rv_data, 32'hDEADBEEF);

    // Write held off behind an in-flight read until expiry.
    ncg = c_gnt_n;
    cq.push_back('{we: 1'b0, addr: 32'h80, wdata: '0});
    wait_c_gnt(ncg + 1);
    dq.push_back('{we: 1'b1, addr: 32'h84, wdata: 32'h1234_5678});
    wait_idle();
    check("t4_gnt_gap", d_gnt_cyc - c_gnt_cyc, LAT);
    check("t4_rv_with_gnt", c_rv_cyc, d_gnt_cyc);

    // Reset while a read is outstanding drops it.
    nrv = c_rv_n;
    ncg = c_gnt_n;
    cq.push_back('{we: 1'b0, addr: 32'hC0, wdata: '0});
    wait_c_gnt(ncg + 1);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("t5_no_rvalid", c_rv_n, nrv);
    n0 = glog.size();
    cq.push_back('{we: 1'b0, addr: 32'h10, wdata: '0});
    dq.push_back('{we: 1'b0, addr: 32'h14, wdata: '0});
    wait_idle();
    if (n0 < glog.size()) check("t5_first_tie", glog[n0], 8'h43);
    else check("t5_first_tie_missing", 1, 0);

`ifdef MEM_ARB_LOCK_EN
    // DMA lock starves the core, round-robin resumes when it drops.
    do_reset();
    n0 = glog.size();
    ncg = c_gnt_n;
    d_lock = 1'b1;
    for (int i = 0; i < 5; i++) dq.push_back('{we: 1'b1, addr: 32'(32'h300 + i * 4), wdata: 32'(i)});
    cq.push_back('{we: 1'b1, addr: 32'h3F0, wdata: 32'h55});
    wait_d_gnt(d_gnt_n + 4);
    check("t6_core_starved", c_gnt_n - ncg, 0);
    d_lock = 1'b0;
    wait_idle();
    for (int i = 0; i < 6; i++)
      if (n0 + i < glog.size()) check("t6_order", glog[n0+i], (i == 4) ? 8'h43 : 8'h44);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
